// File: rtl/gate_test_pkg.sv
// Shared constants for the gate self-test sequencer: golden-function encodings
// and the sequencer FSM state type.
package gate_test_pkg;

  localparam int unsigned OP_AND  = 0;
  localparam int unsigned OP_OR   = 1;
  localparam int unsigned OP_XOR  = 2;
  localparam int unsigned OP_NAND = 3;
  localparam int unsigned OP_NOR  = 4;
  localparam int unsigned OP_XNOR = 5;

  typedef enum logic [1:0] {
    IDLE,
    APPLY,
    CHECK,
    DONE
  } state_e;

endpackage

// File: rtl/gate_test_sequencer_if.sv
// Control/result bundle between the self-test sequencer and its surroundings,
// including the stimulus/response pair of the gate under test.
interface gate_test_sequencer_if #(
  parameter int unsigned N_IN = 2
);

  logic              start;
  logic [N_IN-1:0]   dut_in;
  logic              dut_out;
  logic              busy;
  logic              done;
  logic              pass;
  logic [N_IN:0]     fail_count;
  logic [N_IN-1:0]   first_fail_vec;

  // Sequencer side
  modport master (
    input  start,
    input  dut_out,
    output dut_in,
    output busy,
    output done,
    output pass,
    output fail_count,
    output first_fail_vec
  );

  // Environment side: issues start, hosts the gate, reads results
  modport slave (
    output start,
    output dut_out,
    input  dut_in,
    input  busy,
    input  done,
    input  pass,
    input  fail_count,
    input  first_fail_vec
  );

endinterface

// File: rtl/gate_golden_model.sv
// Combinational reference for the gate under test: a reduction over all input
// bits. With a single input the reductions collapse to the bit or its inverse.
module gate_golden_model
  import gate_test_pkg::*;
#(
  parameter int unsigned N_IN    = 2,
  parameter int unsigned GATE_OP = OP_AND
) (
  input  logic [N_IN-1:0] i_vec,
  output logic            o_expected
);

  // Select the reduction matching the configured gate
  always_comb begin
    o_expected = 1'b0;
    case (GATE_OP)
      OP_AND:  o_expected = &i_vec;
      OP_OR:   o_expected = |i_vec;
      OP_XOR:  o_expected = ^i_vec;
      OP_NAND: o_expected = ~&i_vec;
      OP_NOR:  o_expected = ~|i_vec;
      OP_XNOR: o_expected = ~^i_vec;
      default: o_expected = 1'b0;
    endcase
  end

endmodule

// File: rtl/gate_test_sequencer.sv
// Exhaustive self-test of a small combinational gate: steps through all 2^N_IN
// input vectors, holds each SETTLE cycles, checks the response against the
// golden model and reports mismatch count, first failing vector and pass.
module gate_test_sequencer
  import gate_test_pkg::*;
#(
  parameter int unsigned N_IN    = 2,
  parameter int unsigned GATE_OP = OP_AND,
  parameter int unsigned SETTLE  = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  gate_test_sequencer_if.master io_bus
);

  localparam int unsigned     SW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE - 1);
  // Vector counter carries an extra bit so the last-vector test never relies on wrap
  localparam logic [N_IN:0]   LAST_VEC    = {1'b0, {N_IN{1'b1}}};

  state_e            r_state,          w_state;
  logic [N_IN:0]     r_vec,            w_vec;
  logic [SW-1:0]     r_settle,         w_settle;
  logic [N_IN-1:0]   r_dut_in,         w_dut_in;
  logic              r_busy,           w_busy;
  logic              r_done,           w_done;
  logic              r_pass,           w_pass;
  logic [N_IN:0]     r_fail_count,     w_fail_count;
  logic [N_IN-1:0]   r_first_fail_vec, w_first_fail_vec;
  logic              w_expected;

  gate_golden_model #(
    .N_IN    (N_IN),
    .GATE_OP (GATE_OP)
  ) u_golden (
    .i_vec      (r_vec[N_IN-1:0]),
    .o_expected (w_expected)
  );

  // Next-state and next-output logic for the sequencing FSM
  always_comb begin
    w_state          = r_state;
    w_vec            = r_vec;
    w_settle         = r_settle;
    w_dut_in         = r_dut_in;
    w_busy           = r_busy;
    w_done           = 1'b0;
    w_pass           = r_pass;
    w_fail_count     = r_fail_count;
    w_first_fail_vec = r_first_fail_vec;
    unique case (r_state)
      IDLE: begin
        if (io_bus.start) begin
          w_state          = APPLY;
          w_vec            = '0;
          w_settle         = '0;
          w_dut_in         = '0;
          w_fail_count     = '0;
          w_first_fail_vec = '0;
          w_pass           = 1'b0;
          w_busy           = 1'b1;
        end
      end
      APPLY: begin
        if (r_settle == SETTLE_LAST) begin
          w_settle = '0;
          w_state  = CHECK;
        end else begin
          w_settle = r_settle + SW'(1);
        end
      end
      CHECK: begin
        if (io_bus.dut_out != w_expected) begin
          w_fail_count = r_fail_count + (N_IN + 1)'(1);
          if (r_fail_count == '0) begin
            w_first_fail_vec = r_vec[N_IN-1:0];
          end
        end
        if (r_vec == LAST_VEC) begin
          w_state = DONE;
        end else begin
          w_vec    = r_vec + (N_IN + 1)'(1);
          w_dut_in = r_vec[N_IN-1:0] + N_IN'(1);
          w_state  = APPLY;
        end
      end
      DONE: begin
        // Final CHECK has already been folded into r_fail_count
        w_done  = 1'b1;
        w_busy  = 1'b0;
        w_pass  = (r_fail_count == '0);
        w_state = IDLE;
      end
    endcase
  end

  // State and result registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= IDLE;
      r_vec            <= '0;
      r_settle         <= '0;
      r_dut_in         <= '0;
      r_busy           <= 1'b0;
      r_done           <= 1'b0;
      r_pass           <= 1'b0;
      r_fail_count     <= '0;
      r_first_fail_vec <= '0;
    end else begin
      r_state          <= w_state;
      r_vec            <= w_vec;
      r_settle         <= w_settle;
      r_dut_in         <= w_dut_in;
      r_busy           <= w_busy;
      r_done           <= w_done;
      r_pass           <= w_pass;
      r_fail_count     <= w_fail_count;
      r_first_fail_vec <= w_first_fail_vec;
    end
  end

  assign io_bus.dut_in         = r_dut_in;
  assign io_bus.busy           = r_busy;
  assign io_bus.done           = r_done;
  assign io_bus.pass           = r_pass;
  assign io_bus.fail_count     = r_fail_count;
  assign io_bus.first_fail_vec = r_first_fail_vec;

endmodule

// File: tb/tb_gate_test_sequencer.sv
// Directed bench for gate_test_sequencer: three configurations (AND/SETTLE=1
// with selectable faulty gates, AND/SETTLE=3, XOR3 with start held high).
module tb_gate_test_sequencer;

  logic clk = 1'b0;
  logic rst;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   mode_a  = 0;  // 0 correct AND, 1 stuck-at-0, 2 OR gate

  always #5 clk = ~clk;

  gate_test_sequencer_if #(.N_IN(2)) if_a ();
  gate_test_sequencer_if #(.N_IN(2)) if_b ();
  gate_test_sequencer_if #(.N_IN(3)) if_c ();

  assign if_a.dut_out = (mode_a == 0) ? &if_a.dut_in :
                        (mode_a == 1) ? 1'b0 : |if_a.dut_in;
  assign if_b.dut_out = &if_b.dut_in;
  assign if_c.dut_out = ^if_c.dut_in;

  gate_test_sequencer #(.N_IN(2), .GATE_OP(0), .SETTLE(1)) u_dut_a (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (if_a)
  );

  gate_test_sequencer #(.N_IN(2), .GATE_OP(0), .SETTLE(3)) u_dut_b (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (if_b)
  );

  gate_test_sequencer #(.N_IN(3), .GATE_OP(2), .SETTLE(1)) u_dut_c (
    .i_clk  (clk),
    .i_rst  (rst),
    .io_bus (if_c)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One start pulse on configuration A; watch the run and its results
  task automatic run_a(input string name, input int exp_fail, input int exp_first,
                       input int exp_pass);
    int done_at;
    int done_cnt;
    done_at  = -1;
    done_cnt = 0;
    @(negedge clk);
    if_a.start = 1'b1;
    @(posedge clk);
    #1;
    if_a.start = 1'b0;
    check({name, "_busy_t0"}, if_a.busy, 1);
    check({name, "_dutin_t0"}, if_a.dut_in, 0);
    for (int t = 1; t <= 12; t++) begin
      @(posedge clk);
      #1;
      if (t < 8 && (t % 2) == 0) check($sformatf("%s_dutin_t%0d", name, t), if_a.dut_in, t / 2);
      if (if_a.done) begin
        done_cnt++;
        if (done_at < 0) done_at = t;
      end
    end
    check({name, "_done_edge"}, done_at, 9);
    check({name, "_done_count"}, done_cnt, 1);
    check({name, "_busy_end"}, if_a.busy, 0);
    check({name, "_pass"}, if_a.pass, exp_pass);
    check({name, "_fail_count"}, if_a.fail_count, exp_fail);
    if (exp_fail != 0) check({name, "_first_fail"}, if_a.first_fail_vec, exp_first);
  endtask

  initial begin
    int found;
    int done_cnt;
    int done_at;
    int done_first;
    int done_last;

    rst = 1'b1;
    if_a.start = 1'b0;
    if_b.start = 1'b0;
    if_c.start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", if_a.busy, 0);
    check("rst_done", if_a.done, 0);
    check("rst_pass", if_a.pass, 0);
    check("rst_fail_count", if_a.fail_count, 0);
    check("rst_first_fail", if_a.first_fail_vec, 0);
    check("rst_dutin", if_a.dut_in, 0);
    @(negedge clk);
    rst = 1'b0;

    mode_a = 0; run_a("and_ok", 0, 0, 1);
    mode_a = 1; run_a("stuck0", 1, 3, 0);
    mode_a = 2; run_a("or_dut", 2, 1, 0);

    // Reset mid-run while vector 2'b10 is applied (one mismatch already counted)
    mode_a = 2;
    @(negedge clk);
    if_a.start = 1'b1;
    @(posedge clk);
    #1;
    if_a.start = 1'b0;
    found = 0;
    for (int t = 0; t < 20; t++) begin
      if (if_a.dut_in == 2'b10) begin
        found = 1;
        break;
      end
      @(posedge clk);
      #1;
    end
    check("mid_reach_10", found, 1);
    check("mid_fail_before", if_a.fail_count, 1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_busy", if_a.busy, 0);
    check("mid_dutin", if_a.dut_in, 0);
    check("mid_fail_count", if_a.fail_count, 0);
    check("mid_done", if_a.done, 0);
    @(negedge clk);
    rst = 1'b0;
    done_cnt = 0;
    for (int t = 0; t < 12; t++) begin
      @(posedge clk);
      #1;
      if (if_a.done) done_cnt++;
    end
    check("mid_no_done", done_cnt, 0);
    mode_a = 0; run_a("after_rst", 0, 0, 1);

    // SETTLE=3: each vector held 4 cycles; a start mid-run must be ignored
    @(negedge clk);
    if_b.start = 1'b1;
    @(posedge clk);
    #1;
    if_b.start = 1'b0;
    done_cnt = 0;
    done_at  = -1;
    for (int t = 1; t <= 30; t++) begin
      @(posedge clk);
      #1;
      if (t == 5) if_b.start = 1'b1;
      if (t == 6) if_b.start = 1'b0;
      if (t < 16 && (t % 4) == 0) check($sformatf("s3_dutin_t%0d", t), if_b.dut_in, t / 4);
      if (t < 16 && (t % 4) == 3) check($sformatf("s3_hold_t%0d", t), if_b.dut_in, t / 4);
      if (if_b.done) begin
        done_cnt++;
        if (done_at < 0) done_at = t;
      end
    end
    check("s3_done_edge", done_at, 17);
    check("s3_done_count", done_cnt, 1);
    check("s3_busy_end", if_b.busy, 0);
    check("s3_pass", if_b.pass, 1);
    check("s3_fail_count", if_b.fail_count, 0);

    // XOR3 with start held high: back-to-back runs, each 17 edges plus one IDLE cycle
    @(negedge clk);
    if_c.start = 1'b1;
    @(posedge clk);
    #1;
    done_cnt   = 0;
    done_first = -1;
    done_last  = -1;
    for (int t = 1; t <= 60; t++) begin
      @(posedge clk);
      #1;
      if (t < 16 && (t % 2) == 0) check($sformatf("x3_dutin_t%0d", t), if_c.dut_in, t / 2);
      if (t == 18) check("x3_pass_cleared", if_c.pass, 0);
      if (t == 18) check("x3_busy_rerun", if_c.busy, 1);
      if (if_c.done) begin
        done_cnt++;
        if (done_first < 0) done_first = t;
        done_last = t;
        check($sformatf("x3_pass_t%0d", t), if_c.pass, 1);
        check($sformatf("x3_fail_t%0d", t), if_c.fail_count, 0);
      end
    end
    if_c.start = 1'b0;
    check("x3_first_done", done_first, 17);
    check("x3_done_count", done_cnt, 3);
    check("x3_last_done", done_last, 53);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "bench timeout");
  end

endmodule
